// File: rtl/kb_ps2_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: bus widths,
// register map, register bit positions and receiver state encoding.
package kb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  // Register offsets, decoded from adr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // DATA register
  localparam int unsigned DATA_VALID = 8;

  // STATUS register
  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_OVR    = 2;
  localparam int unsigned STAT_PERR   = 3;
  localparam int unsigned STAT_FERR   = 4;
  localparam int unsigned STAT_CNT_LO = 8;

  // CTRL register
  localparam int unsigned CTRL_RXIE  = 0;
  localparam int unsigned CTRL_ERRIE = 1;
  localparam int unsigned CTRL_FLUSH = 2;
  localparam int unsigned CTRL_EN    = 3;

  // Receiver frame states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // PS/2 uses odd parity across the eight data bits plus the parity bit
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kb_ps2_ctrl_if.sv
// Wishbone slave bus bundle for the PS/2 keyboard controller.
interface kb_ps2_ctrl_if;
  import kb_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [WB_SW-1:0] sel;
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] dat_w;
  logic [WB_DW-1:0] dat_r;
  logic             ack;
  logic             irq;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, irq
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, irq
  );

endinterface

// File: rtl/kb_ps2_ctrl_fifo.sv
// Byte FIFO for received scan codes. A push while full is accepted only
// when a pop happens in the same cycle; flush empties it immediately.
module kb_rx_fifo
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kb_ps2_ctrl.sv
// PS/2 keyboard receiver with a Wishbone register interface: synchronises
// and filters the PS/2 lines, decodes 11-bit frames, queues scan codes and
// raises a level interrupt on data or error conditions.
module kb_ps2_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [WB_SW-1:0] sel_i,
  input  logic [WB_AW-1:0] adr_i,
  input  logic [WB_DW-1:0] dat_i,
  output logic [WB_DW-1:0] dat_o,
  output logic             ack_o,
  output logic             int_o,
  input  logic             kb_clk_i,
  input  logic             kb_dat_i
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             flt_clk;
  logic             flt_prev;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall_d;
  logic             ps2_bit;

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             rx_push;
  logic             perr_set;
  logic             ferr_set;

  logic             ovr;
  logic             perr;
  logic             ferr;
  logic             ctrl_rxie;
  logic             ctrl_errie;
  logic             ctrl_en;

  logic [1:0]       reg_ofs;
  logic             bus_acc;
  logic             wr_status;
  logic             wr_ctrl;
  logic             rd_data;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             ovr_set;

  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [8:0]       count_wide;
  logic [7:0]       count_rep;

  logic             unused_bits;
  assign unused_bits = ^{adr_i[WB_AW-1:4], adr_i[1:0], sel_i[WB_SW-1:1], dat_i[WB_DW-1:5]};

  assign ps2_bit = dat_sync[1];

  // Two-flop synchronisers for both PS/2 lines (idle high)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], kb_clk_i};
      dat_sync <= {dat_sync[0], kb_dat_i};
    end
  end

  // Glitch filter on kb_clk and delayed falling-edge strobe for sampling
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flt_clk  <= 1'b1;
      flt_prev <= 1'b1;
      flt_cnt  <= '0;
      fall_d   <= 1'b0;
    end else begin
      flt_prev <= flt_clk;
      fall_d   <= flt_prev & ~flt_clk;
      if (clk_sync[1] == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_clk <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Frame completion, error detection and inactivity timeout
  always_comb begin
    rx_push  = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    tmo_hit  = (state != RX_IDLE) && !fall_d && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    if (ctrl_en && fall_d && state == RX_STOP) begin
      if (ps2_bit) begin
        if (parity_ok(shreg, par_bit)) rx_push  = 1'b1;
        else                           perr_set = 1'b1;
      end else begin
        ferr_set = 1'b1;
      end
    end
    if (ctrl_en && tmo_hit) ferr_set = 1'b1;
  end

  // Cycles since the last sampled falling edge while a frame is in progress
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                               tmo_cnt <= '0;
    else if (!ctrl_en || state == RX_IDLE || fall_d || tmo_hit) tmo_cnt <= '0;
    else                                                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Frame receiver state machine, advanced once per sampled bit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (!ctrl_en || tmo_hit) begin
      state <= RX_IDLE;
    end else if (fall_d) begin
      case (state)
        RX_IDLE: begin
          if (!ps2_bit) begin
            state   <= RX_DATA;
            bit_cnt <= '0;
          end
        end
        RX_DATA: begin
          shreg   <= {ps2_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= RX_PARITY;
        end
        RX_PARITY: begin
          par_bit <= ps2_bit;
          state   <= RX_STOP;
        end
        RX_STOP: state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

  kb_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (rx_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (shreg),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accesses take effect in the ack cycle while the master still holds them
  assign reg_ofs    = adr_i[3:2];
  assign bus_acc    = cyc_i & stb_i & ack_o;
  assign wr_status  = bus_acc & we_i & sel_i[0] & (reg_ofs == REG_STATUS);
  assign wr_ctrl    = bus_acc & we_i & sel_i[0] & (reg_ofs == REG_CTRL);
  assign rd_data    = bus_acc & ~we_i & (reg_ofs == REG_DATA);
  assign fifo_pop   = rd_data & ~fifo_empty;
  assign fifo_flush = wr_ctrl & dat_i[CTRL_FLUSH];
  assign ovr_set    = rx_push & fifo_full & ~fifo_pop;

  // Single-cycle acknowledge, zero wait states
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ack_o <= 1'b0;
    else        ack_o <= cyc_i & stb_i & ~ack_o;
  end

  // Sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovr  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(wr_status & dat_i[STAT_OVR]));
      perr <= perr_set | (perr & ~(wr_status & dat_i[STAT_PERR]));
      ferr <= ferr_set | (ferr & ~(wr_status & dat_i[STAT_FERR]));
    end
  end

  // Control register (flush is a strobe and is not stored)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_rxie  <= 1'b0;
      ctrl_errie <= 1'b0;
      ctrl_en    <= 1'b1;
    end else if (wr_ctrl) begin
      ctrl_rxie  <= dat_i[CTRL_RXIE];
      ctrl_errie <= dat_i[CTRL_ERRIE];
      ctrl_en    <= dat_i[CTRL_EN];
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) int_o <= 1'b0;
    else        int_o <= (ctrl_rxie & ~fifo_empty) | (ctrl_errie & (ovr | perr | ferr));
  end

  // Count saturates for the 256-deep configuration
  assign count_wide = 9'(fifo_count);
  assign count_rep  = count_wide[8] ? 8'hFF : count_wide[7:0];

  // Read data mux, driven only during the ack cycle
  always_comb begin
    dat_o = '0;
    if (ack_o) begin
      case (reg_ofs)
        REG_DATA: begin
          dat_o[DATA_VALID] = ~fifo_empty;
          dat_o[7:0]        = fifo_empty ? 8'h00 : fifo_head;
        end
        REG_STATUS: begin
          dat_o[STAT_EMPTY]           = fifo_empty;
          dat_o[STAT_FULL]            = fifo_full;
          dat_o[STAT_OVR]             = ovr;
          dat_o[STAT_PERR]            = perr;
          dat_o[STAT_FERR]            = ferr;
          dat_o[STAT_CNT_LO +: 8]     = count_rep;
        end
        REG_CTRL: begin
          dat_o[CTRL_RXIE]  = ctrl_rxie;
          dat_o[CTRL_ERRIE] = ctrl_errie;
          dat_o[CTRL_EN]    = ctrl_en;
        end
        default: dat_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_kb_ps2_ctrl.sv
// Self-checking bench for kb_ps2_ctrl: drives PS/2 frames and Wishbone
// accesses and compares register reads against a queue-based model.
module tb_kb_ps2_ctrl;
  import kb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned FLT   = 8;
  localparam int unsigned TMO   = 1000;
  localparam int unsigned HALF  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kb_clk = 1'b1;
  logic kb_dat = 1'b1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] q[$];
  logic m_ovr, m_perr, m_ferr;

  kb_ps2_ctrl_if bus();

  always #5 clk = ~clk;

  kb_ps2_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (FLT),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .cyc_i    (bus.cyc),
    .stb_i    (bus.stb),
    .we_i     (bus.we),
    .sel_i    (bus.sel),
    .adr_i    (bus.adr),
    .dat_i    (bus.dat_w),
    .dat_o    (bus.dat_r),
    .ack_o    (bus.ack),
    .int_o    (bus.irq),
    .kb_clk_i (kb_clk),
    .kb_dat_i (kb_dat)
  );

  // ---------------- reference model ----------------
  function automatic void model_reset();
    q.delete();
    m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic par_good, input logic stop);
    if (!stop)                 m_ferr = 1'b1;
    else if (!par_good)        m_perr = 1'b1;
    else if (q.size() >= DEPTH) m_ovr = 1'b1;
    else                       q.push_back(d);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (q.size() == 0);
    s[1]    = (q.size() == DEPTH);
    s[2]    = m_ovr;
    s[3]    = m_perr;
    s[4]    = m_ferr;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_data_pop();
    logic [31:0] v;
    v = '0;
    if (q.size() != 0) v = {23'd0, 1'b1, q.pop_front()};
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic ps2_bit(input logic b);
    kb_dat = b;
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop);
    logic p;
    p = par_good ? ~^d : ^d;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop);
    kb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wb_cycle(input logic [1:0] ofs, input logic we, input logic [31:0] wdata,
                          input logic [3:0] sel, output logic [31:0] rdata);
    int unsigned n;
    n = 0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = {28'd0, ofs, 2'b00}; bus.dat_w = wdata; bus.sel = sel;
    @(negedge clk);
    while (bus.ack !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    rdata = bus.dat_r;
    if (bus.ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_timeout got=%b want=1", bus.ack);
      rdata = '0;
    end
    @(posedge clk);
    #1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [1:0] ofs, output logic [31:0] rdata);
    wb_cycle(ofs, 1'b0, 32'd0, 4'hF, rdata);
  endtask

  task automatic wb_write(input logic [1:0] ofs, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_cycle(ofs, 1'b1, wdata, sel, dummy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", bus.ack); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_int got=%b want=0", bus.irq); end
    checks++; if (bus.dat_r !== 32'd0) begin errors++; $display("FAIL reset_dat got=%h want=0", bus.dat_r); end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL reset_status got=%h want=%h", rd, exp_status()); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL ack_single_cycle got=%b want=0", bus.ack); end
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL reset_ctrl got=%h want=00000008", rd); end
    wb_read(REG_RSVD, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reserved_read got=%h want=0", rd); end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd, want;
    wb_write(REG_CTRL, 32'h09, 4'h1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rx_int_empty got=%b want=0", bus.irq); end
    send_frame(8'h1C, 1'b1, 1'b1);
    model_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL rx_int_data got=%b want=1", bus.irq); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL single_status got=%h want=%h", rd, exp_status()); end
    want = exp_data_pop();
    wb_read(REG_DATA, rd);
    checks++; if (rd !== want) begin errors++; $display("FAIL single_data got=%h want=%h", rd, want); end
    repeat (2) @(negedge clk);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rx_int_drained got=%b want=0", bus.irq); end
    wb_read(REG_DATA, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL empty_data got=%h want=0", rd); end
  endtask

  task automatic test_parity_error();
    logic [31:0] rd;
    wb_write(REG_CTRL, 32'h0A, 4'h1);
    send_frame(8'hF0, 1'b0, 1'b1);
    model_frame(8'hF0, 1'b0, 1'b1);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL perr_status got=%h want=%h", rd, exp_status()); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL perr_int got=%b want=1", bus.irq); end
    wb_write(REG_STATUS, 32'h08, 4'h1);
    m_perr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL perr_int_clear got=%b want=0", bus.irq); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL perr_clear_status got=%h want=%h", rd, exp_status()); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, want;
    wb_write(REG_CTRL, 32'h08, 4'h1);
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      model_frame(8'(i), 1'b1, 1'b1);
    end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL ovr_status got=%h want=%h", rd, exp_status()); end
    for (int i = 0; i < 16; i++) begin
      want = exp_data_pop();
      wb_read(REG_DATA, rd);
      checks++; if (rd !== want) begin errors++; $display("FAIL ovr_order[%0d] got=%h want=%h", i, rd, want); end
    end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL ovr_drained got=%h want=%h", rd, exp_status()); end
    wb_write(REG_STATUS, 32'h04, 4'h1);
    m_ovr = 1'b0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd, want;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    kb_dat = 1'b1;
    repeat (TMO + 1) @(negedge clk);
    m_ferr = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b1);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL timeout_status got=%h want=%h", rd, exp_status()); end
    want = exp_data_pop();
    wb_read(REG_DATA, rd);
    checks++; if (rd !== want) begin errors++; $display("FAIL timeout_data got=%h want=%h", rd, want); end
    wb_write(REG_STATUS, 32'h10, 4'h1);
    m_ferr = 1'b0;
  endtask

  task automatic test_glitch();
    logic [31:0] rd, want;
    int unsigned len;
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, FLT - 1);
      kb_dat = 1'b0;
      kb_clk = 1'b0;
      repeat (len) @(negedge clk);
      kb_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    kb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL glitch_status got=%h want=%h", rd, exp_status()); end
    send_frame(8'h3C, 1'b1, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b1);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL glitch_frame_status got=%h want=%h", rd, exp_status()); end
    want = exp_data_pop();
    wb_read(REG_DATA, rd);
    checks++; if (rd !== want) begin errors++; $display("FAIL glitch_frame_data got=%h want=%h", rd, want); end
  endtask

  task automatic test_random_frames();
    logic [31:0] rd, want;
    logic [7:0]  d;
    int unsigned kind;
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 4);
      send_frame(d, kind != 0, kind != 1);
      model_frame(d, kind != 0, kind != 1);
      wb_read(REG_STATUS, rd);
      checks++; if (rd !== exp_status()) begin errors++; $display("FAIL rand_status[%0d] got=%h want=%h", i, rd, exp_status()); end
    end
    while (q.size() != 0) begin
      want = exp_data_pop();
      wb_read(REG_DATA, rd);
      checks++; if (rd !== want) begin errors++; $display("FAIL rand_data got=%h want=%h", rd, want); end
    end
    wb_write(REG_STATUS, 32'h1C, 4'h1);
    m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL rand_clear got=%h want=%h", rd, exp_status()); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd, want;
    logic [7:0]  d, nd;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'b1);
      model_frame(d, 1'b1, 1'b1);
    end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL full_status got=%h want=%h", rd, exp_status()); end
    nd = 8'($urandom);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(nd[i]);
    ps2_bit(~^nd);
    kb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b0;
    // Stop bit is sampled 2 (sync) + FLT (filter) + 2 cycles after this edge;
    // the read's ack cycle lands there. An earlier pop yields the same outcome.
    repeat (FLT + 2) @(negedge clk);
    want = exp_data_pop();
    q.push_back(nd);
    wb_read(REG_DATA, rd);
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    checks++; if (rd !== want) begin errors++; $display("FAIL pushpop_data got=%h want=%h", rd, want); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL pushpop_status got=%h want=%h", rd, exp_status()); end
    for (int i = 0; i < DEPTH; i++) begin
      want = exp_data_pop();
      wb_read(REG_DATA, rd);
      checks++; if (rd !== want) begin errors++; $display("FAIL pushpop_order[%0d] got=%h want=%h", i, rd, want); end
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd, want;
    wb_write(REG_CTRL, 32'h00, 4'h1);
    send_frame(8'h77, 1'b1, 1'b1);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL disabled_status got=%h want=%h", rd, exp_status()); end
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL ctrl_readback got=%h want=0", rd); end
    wb_write(REG_CTRL, 32'h08, 4'h1);
    send_frame(8'h42, 1'b1, 1'b1);
    model_frame(8'h42, 1'b1, 1'b1);
    // Disable mid-frame: the partial frame goes, the queued byte stays
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom));
    wb_write(REG_CTRL, 32'h00, 4'h1);
    for (int i = 0; i < 7; i++) ps2_bit(1'($urandom));
    kb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    wb_write(REG_CTRL, 32'h08, 4'h1);
    wb_write(REG_DATA, 32'hFF, 4'hF);
    wb_write(REG_RSVD, 32'hFFFF_FFFF, 4'hF);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL en_retain_status got=%h want=%h", rd, exp_status()); end
    want = exp_data_pop();
    wb_read(REG_DATA, rd);
    checks++; if (rd !== want) begin errors++; $display("FAIL en_retain_data got=%h want=%h", rd, want); end
    send_frame(8'h11, 1'b1, 1'b1);
    model_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    model_frame(8'h22, 1'b1, 1'b1);
    wb_write(REG_CTRL, 32'h0C, 4'h1);
    q.delete();
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL flush_status got=%h want=%h", rd, exp_status()); end
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL flush_ctrl got=%h want=00000008", rd); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd, want;
    wb_write(REG_CTRL, 32'h09, 4'h1);
    send_frame(8'h99, 1'b1, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom));
    kb_dat = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL midreset_int got=%b want=0", bus.irq); end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL midreset_ctrl got=%h want=00000008", rd); end
    send_frame(8'hA5, 1'b1, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b1);
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL midreset_status got=%h want=%h", rd, exp_status()); end
    want = exp_data_pop();
    wb_read(REG_DATA, rd);
    checks++; if (rd !== want) begin errors++; $display("FAIL midreset_data got=%h want=%h", rd, want); end
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.sel = '0; bus.adr = '0; bus.dat_w = '0;
    model_reset();
    test_reset();
    test_single_frame();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_glitch();
    test_random_frames();
    test_full_push_pop();
    test_ctrl();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/kb_ps2_ctrl.md
KB_PS2_CTRL -- requirements
Module: kb_ps2_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, the scan-code FIFO depth (power of two, 2..256).
REQ-002 SHALL have parameter FILTER_LEN, default 8, the consecutive equal samples needed to accept a kb_clk_i level change.
REQ-003 SHALL have parameter TIMEOUT, default 20000, the clk_i cycles without a falling kb_clk edge before a partial frame is abandoned.
REQ-004 SHALL have port clk_i  in  1  system clock; the block has one clock only.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-007 SHALL have ports sel_i  in  4, adr_i  in  32, dat_i  in  32  byte selects, address (adr_i[3:2] decoded), write data.
REQ-008 SHALL have ports dat_o  out  32, ack_o  out  1, int_o  out  1  read data, acknowledge, level interrupt.
REQ-009 SHALL have ports kb_clk_i, kb_dat_i  in  1 each  asynchronous PS/2 clock and data.

Function
REQ-010 SHALL pass kb_clk_i and kb_dat_i through 2-flop synchronisers; filtered kb_clk SHALL change only after FILTER_LEN equal synchronised samples.
REQ-011 SHALL sample synchronised kb_dat on each filtered kb_clk falling edge, one clk_i cycle after the edge is detected.
REQ-012 SHALL run an FSM: IDLE, DATA, PARITY, STOP; in IDLE a sampled 0 enters DATA, a sampled 1 stays in IDLE.
REQ-013 DATA SHALL shift 8 bits LSB first and move to PARITY after bit 7; PARITY SHALL capture the parity bit and move to STOP.
REQ-014 In STOP the FSM SHALL return to IDLE; with stop=1 and odd parity over data+parity the byte is pushed; a parity failure sets PERR; stop=0 sets FERR; a failed frame is discarded.
REQ-015 Outside IDLE, TIMEOUT cycles without a falling edge SHALL return the FSM to IDLE, discard the partial frame and set FERR.
REQ-016 A push while full SHALL be dropped and set sticky OVR; a simultaneous push and pop while full SHALL accept the push, with count unchanged.
REQ-017 A simultaneous push and pop at any count SHALL leave count unchanged and preserve FIFO order.
REQ-018 ack_o SHALL assert one cycle after cyc_i&stb_i&!ack_o and stay high for exactly one cycle per access; zero wait states.
REQ-019 Offset 0 (DATA) read: dat_o[8]=valid, dat_o[7:0]=FIFO head; the FIFO SHALL pop in the ack cycle only if non-empty; an empty read returns 0; DATA writes are ignored.
REQ-020 Offset 1 (STATUS) read: [0] empty, [1] full, [2] OVR, [3] PERR, [4] FERR, [15:8] count; a write with sel_i[0]=1 SHALL clear each of bits 2..4 written as 1.
REQ-021 Offset 2 (CTRL) read/write, byte 0 only: [0] RXIE, [1] ERRIE, [2] FLUSH (write 1 empties the FIFO same cycle, reads 0), [3] EN.
REQ-022 With EN=0 the FSM SHALL be held in IDLE, discarding any partial frame; FIFO contents are retained.
REQ-023 Offset 3 SHALL read 0 and ignore writes; dat_o SHALL be 0 whenever ack_o is low.
REQ-024 int_o SHALL be registered: (RXIE & !empty) | (ERRIE & (OVR|PERR|FERR)).
REQ-025 A sticky-flag set and a W1C clear in the same cycle SHALL leave the flag set.

Reset
REQ-026 rst_i low SHALL asynchronously force ack_o=0, int_o=0, dat_o=0, FIFO empty, count 0, OVR/PERR/FERR=0, CTRL=0x08, FSM IDLE, filter and synchronisers to 1, timeout counter 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; the first complete frame after release SHALL decode correctly.

Structure
REQ-028 A shared package kb_pkg SHALL hold register offsets, STATUS/CTRL bit indices and the FSM state enum.
REQ-029 The FIFO SHALL be one sub-module, kb_rx_fifo (parameter DEPTH, 8-bit width, push/pop/flush, count/full/empty).

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> STATUS count=1; DATA read=0x11C; next DATA read=0x000; int_o high only while non-empty with RXIE=1.
REQ-031 Frame 0xF0 with parity 0 (bad) -> count=0, PERR=1, int_o=1 with ERRIE=1; STATUS write 0x08 -> PERR=0, int_o=0.
REQ-032 17 frames 0x01..0x11, FIFO_DEPTH=16 -> count=16, full=1, OVR=1; reads return 0x101..0x110 in order.
REQ-033 Start + 4 data bits, stall TIMEOUT+1 cycles, then frame 0x5A -> FERR=1, FIFO holds only 0x5A.
REQ-034 3-cycle low glitch on kb_clk_i (FILTER_LEN=8) -> no FSM change, no bit sampled.
REQ-035 FIFO full, frame completes in the ack cycle of a DATA read -> count stays 16, OVR stays 0, new byte last in order.
